aud_mode_ctrl: RTL and testbench

//  Top-level mode sequencer for the audio recorder. It turns debounced key pulses into

---
 rtl/aud_pkg.sv | 36 +++
 rtl/aud_cmd_arb.sv | 30 +++
 rtl/aud_mode_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_aud_mode_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aud_pkg
//  Description : Shared types and constants for the audio recorder mode
//                sequencer: state and command encodings, SRAM address width
//                and the reset playback speed.
//  Revision    : 1.0 - initial release
// ============================================================================
package aud_pkg;

    // SRAM word-address width
    localparam int ADDR_W = 20;

    // Speed code handed to AudDSP out of reset (1x playback)
    localparam logic [2:0] SPEED_1X = 3'd3;

    // Sequencer state, 3-bit explicit encoding (also shown on the display)
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_REC_PAUSE  = 3'd2,
        ST_PLAY       = 3'd3,
        ST_PLAY_PAUSE = 3'd4
    } aud_state_e;

    // Arbitrated key command, one per cycle
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_STOP  = 3'd1,
        CMD_PAUSE = 3'd2,
        CMD_REC   = 3'd3,
        CMD_PLAY  = 3'd4
    } aud_cmd_e;

endpackage : aud_pkg
`default_nettype wire

// File: rtl/aud_cmd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : aud_cmd_arb
//  Description : Combinational priority encoder for the four key pulses.
//                Priority is stop > pause > rec > play; lower keys that
//                arrive in the same cycle are dropped.
//  Ports       : i_key_rec/i_key_play/i_key_pause/i_key_stop  key pulses
//                o_cmd                                        winning command
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_cmd_arb
    import aud_pkg::*;
(
    input  logic     i_key_rec,
    input  logic     i_key_play,
    input  logic     i_key_pause,
    input  logic     i_key_stop,
    output aud_cmd_e o_cmd
);

    always_comb begin
        o_cmd = CMD_NONE;
        if (i_key_stop)       o_cmd = CMD_STOP;
        else if (i_key_pause) o_cmd = CMD_PAUSE;
        else if (i_key_rec)   o_cmd = CMD_REC;
        else if (i_key_play)  o_cmd = CMD_PLAY;
    end

endmodule : aud_cmd_arb
`default_nettype wire

// File: rtl/aud_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aud_mode_ctrl
//  Description : Top-level mode sequencer for the audio recorder. Turns key
//                pulses into registered single-cycle start/pause/stop
//                commands for the recorder and AudDSP, owns the shared SRAM
//                address / write-enable mux and latches the recorded end
//                address.
//  Ports       : i_clk, i_rst_n (async, active low)
//                i_key_rec/play/pause/stop    1-cycle key pulses
//                i_speed, i_interp_mode       playback settings to latch
//                i_rec_addr, i_dsp_addr       recorder / AudDSP addresses
//                o_rec_start/pause/stop       recorder command pulses
//                o_dsp_start/pause/stop       AudDSP command pulses
//                o_dsp_speed, o_dsp_mode      latched playback settings
//                o_sram_addr, o_sram_we_n     SRAM mux outputs
//                o_end_addr                   last recorded address
//                o_state                      current state for display
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_mode_ctrl
    import aud_pkg::*;
#(
    parameter int                  ADDR_W   = aud_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]   MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic [2:0]        i_speed,
    input  logic              i_interp_mode,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [ADDR_W-1:0] i_dsp_addr,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_dsp_start,
    output logic              o_dsp_pause,
    output logic              o_dsp_stop,
    output logic [2:0]        o_dsp_speed,
    output logic              o_dsp_mode,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic [2:0]        o_state
);

    aud_cmd_e          w_cmd;
    aud_state_e        r_state;
    logic              r_rec_start;
    logic              r_rec_pause;
    logic              r_rec_stop;
    logic              r_dsp_start;
    logic              r_dsp_pause;
    logic              r_dsp_stop;
    logic [2:0]        r_dsp_speed;
    logic              r_dsp_mode;
    logic [ADDR_W-1:0] r_end_addr;
    logic              w_rec_at_max;
    logic              w_play_done;
    logic [ADDR_W-1:0] w_sram_addr;
    logic              w_sram_we_n;

    aud_cmd_arb u_cmd_arb (
        .i_key_rec   (i_key_rec),
        .i_key_play  (i_key_play),
        .i_key_pause (i_key_pause),
        .i_key_stop  (i_key_stop),
        .o_cmd       (w_cmd)
    );

    // Recording ends on its own once the last writable word is addressed;
    // playback ends once the reader reaches the recorded end.
    assign w_rec_at_max = (i_rec_addr == MAX_ADDR);
    assign w_play_done  = (i_dsp_addr >= r_end_addr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_rec_start <= 1'b0;
            r_rec_pause <= 1'b0;
            r_rec_stop  <= 1'b0;
            r_dsp_start <= 1'b0;
            r_dsp_pause <= 1'b0;
            r_dsp_stop  <= 1'b0;
            r_dsp_speed <= SPEED_1X;
            r_dsp_mode  <= 1'b0;
            r_end_addr  <= '0;
        end else begin
            // Pulses are one cycle wide unless re-raised below
            r_rec_start <= 1'b0;
            r_rec_pause <= 1'b0;
            r_rec_stop  <= 1'b0;
            r_dsp_start <= 1'b0;
            r_dsp_pause <= 1'b0;
            r_dsp_stop  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_cmd == CMD_REC) begin
                        r_state     <= ST_REC;
                        r_rec_start <= 1'b1;
                    end else if (w_cmd == CMD_PLAY && r_end_addr != '0) begin
                        // Nothing to play back until something was recorded
                        r_state     <= ST_PLAY;
                        r_dsp_start <= 1'b1;
                        r_dsp_speed <= i_speed;
                        r_dsp_mode  <= i_interp_mode;
                    end
                end

                ST_REC: begin
                    if (w_cmd == CMD_STOP || w_rec_at_max) begin
                        // On auto-stop i_rec_addr equals MAX_ADDR anyway
                        r_state    <= ST_IDLE;
                        r_rec_stop <= 1'b1;
                        r_end_addr <= i_rec_addr;
                    end else if (w_cmd == CMD_PAUSE) begin
                        r_state     <= ST_REC_PAUSE;
                        r_rec_pause <= 1'b1;
                    end
                end

                ST_REC_PAUSE: begin
                    if (w_cmd == CMD_STOP) begin
                        r_state    <= ST_IDLE;
                        r_rec_stop <= 1'b1;
                        r_end_addr <= i_rec_addr;
                    end else if (w_cmd == CMD_PAUSE || w_cmd == CMD_REC) begin
                        r_state     <= ST_REC;
                        r_rec_start <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    // User stop and end-of-data collapse into one pulse
                    if (w_cmd == CMD_STOP || w_play_done) begin
                        r_state    <= ST_IDLE;
                        r_dsp_stop <= 1'b1;
                    end else if (w_cmd == CMD_PAUSE) begin
                        r_state     <= ST_PLAY_PAUSE;
                        r_dsp_pause <= 1'b1;
                    end
                end

                ST_PLAY_PAUSE: begin
                    if (w_cmd == CMD_STOP) begin
                        r_state    <= ST_IDLE;
                        r_dsp_stop <= 1'b1;
                    end else if (w_cmd == CMD_PAUSE || w_cmd == CMD_PLAY) begin
                        r_state     <= ST_PLAY;
                        r_dsp_start <= 1'b1;
                        r_dsp_speed <= i_speed;
                        r_dsp_mode  <= i_interp_mode;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // SRAM mux straight off the state register, no added latency. The write
    // at MAX_ADDR still happens in the auto-stop cycle since r_state is REC.
    always_comb begin
        w_sram_addr = i_dsp_addr;
        w_sram_we_n = 1'b1;
        case (r_state)
            ST_REC: begin
                w_sram_addr = i_rec_addr;
                w_sram_we_n = 1'b0;
            end
            ST_REC_PAUSE: begin
                w_sram_addr = i_rec_addr;
            end
            default: begin
                w_sram_addr = i_dsp_addr;
                w_sram_we_n = 1'b1;
            end
        endcase
    end

    assign o_rec_start = r_rec_start;
    assign o_rec_pause = r_rec_pause;
    assign o_rec_stop  = r_rec_stop;
    assign o_dsp_start = r_dsp_start;
    assign o_dsp_pause = r_dsp_pause;
    assign o_dsp_stop  = r_dsp_stop;
    assign o_dsp_speed = r_dsp_speed;
    assign o_dsp_mode  = r_dsp_mode;
    assign o_sram_addr = w_sram_addr;
    assign o_sram_we_n = w_sram_we_n;
    assign o_end_addr  = r_end_addr;
    assign o_state     = r_state;

endmodule : aud_mode_ctrl
`default_nettype wire

// File: tb/tb_aud_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aud_mode_ctrl
//  Description : Self-checking bench for aud_mode_ctrl. Directed scenarios
//                followed by random key traffic, all compared against a
//                flag-based behavioural model of the recorder modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_mode_ctrl;
    import aud_pkg::*;

    localparam logic [19:0] c_max = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_rec = 1'b0, key_play = 1'b0, key_pause = 1'b0, key_stop = 1'b0;
    logic [2:0]  speed = 3'd3;
    logic        interp = 1'b0;
    logic [19:0] rec_addr = '0, dsp_addr = '0;

    logic        rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop;
    logic [2:0]  dsp_speed, state;
    logic        dsp_mode, sram_we_n;
    logic [19:0] sram_addr, end_addr;

    aud_mode_ctrl #(.ADDR_W(20), .MAX_ADDR(c_max)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_rec(key_rec), .i_key_play(key_play),
        .i_key_pause(key_pause), .i_key_stop(key_stop),
        .i_speed(speed), .i_interp_mode(interp),
        .i_rec_addr(rec_addr), .i_dsp_addr(dsp_addr),
        .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
        .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause), .o_dsp_stop(dsp_stop),
        .o_dsp_speed(dsp_speed), .o_dsp_mode(dsp_mode),
        .o_sram_addr(sram_addr), .o_sram_we_n(sram_we_n),
        .o_end_addr(end_addr), .o_state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: a session flag per activity plus a pause flag
    bit          m_rec, m_play, m_paused;
    logic [19:0] m_end;
    logic [2:0]  m_speed;
    logic        m_mode;
    logic [5:0]  m_pulse;   // {rs, rp, rt, ds, dp, dt}

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rec = 0; m_play = 0; m_paused = 0;
        m_end = '0; m_speed = 3'd3; m_mode = 1'b0; m_pulse = '0;
    endtask

    task automatic model_step(input bit kr, input bit kp, input bit kpa, input bit ks);
        bit stop, pause, rec, play;
        stop  = ks;
        pause = !stop && kpa;
        rec   = !stop && !pause && kr;
        play  = !stop && !pause && !rec && kp;
        m_pulse = '0;
        if (m_rec) begin
            if (stop || (!m_paused && rec_addr == c_max)) begin
                m_pulse[3] = 1; m_end = rec_addr; m_rec = 0; m_paused = 0;
            end else if (!m_paused && pause) begin
                m_paused = 1; m_pulse[4] = 1;
            end else if (m_paused && (pause || rec)) begin
                m_paused = 0; m_pulse[5] = 1;
            end
        end else if (m_play) begin
            if (stop || (!m_paused && dsp_addr >= m_end)) begin
                m_pulse[0] = 1; m_play = 0; m_paused = 0;
            end else if (!m_paused && pause) begin
                m_paused = 1; m_pulse[1] = 1;
            end else if (m_paused && (pause || play)) begin
                m_paused = 0; m_pulse[2] = 1; m_speed = speed; m_mode = interp;
            end
        end else begin
            if (rec) begin
                m_rec = 1; m_pulse[5] = 1;
            end else if (play && m_end != 0) begin
                m_play = 1; m_pulse[2] = 1; m_speed = speed; m_mode = interp;
            end
        end
    endtask

    function automatic logic [2:0] exp_state();
        if (m_rec)  return m_paused ? ST_REC_PAUSE : ST_REC;
        if (m_play) return m_paused ? ST_PLAY_PAUSE : ST_PLAY;
        return ST_IDLE;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pulses"}, 32'({rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}), 32'(m_pulse));
        chk({tag, ".state"}, 32'(state), 32'(exp_state()));
        chk({tag, ".end_addr"}, 32'(end_addr), 32'(m_end));
        chk({tag, ".speed"}, 32'(dsp_speed), 32'(m_speed));
        chk({tag, ".mode"}, 32'(dsp_mode), 32'(m_mode));
        chk({tag, ".sram_addr"}, 32'(sram_addr), 32'(m_rec ? rec_addr : dsp_addr));
        chk({tag, ".we_n"}, 32'(sram_we_n), 32'(!(m_rec && !m_paused)));
    endtask

    // Present keys for exactly one active edge, then compare 1 unit after it
    task automatic step(input string tag, input bit kr, input bit kp, input bit kpa, input bit ks);
        @(negedge clk);
        key_rec = kr; key_play = kp; key_pause = kpa; key_stop = ks;
        model_step(kr, kp, kpa, ks);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nstop;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Play with nothing recorded is ignored
        step("t3_play_empty", 0, 1, 0, 0);
        step("t3_idle", 0, 0, 0, 0);

        // Record 0..0x3FF then stop
        rec_addr = '0;
        step("t1_rec", 1, 0, 0, 0);
        chk("t1_rec_start", 32'(rec_start), 32'd1);
        for (int i = 0; i <= 'h3FF; i++) begin
            rec_addr = 20'(i);
            step("t1_sweep", 0, 0, 0, 0);
        end
        step("t1_stop", 0, 0, 0, 1);
        chk("t1_rec_stop", 32'(rec_stop), 32'd1);
        chk("t1_end_addr", 32'(end_addr), 32'h3FF);
        step("t1_after", 0, 0, 0, 0);
        chk("t1_rec_stop_1cyc", 32'(rec_stop), 32'd0);

        // Play at speed 5 until the end address is reached
        speed = 3'd5; interp = 1'b1; dsp_addr = '0;
        step("t2_play", 0, 1, 0, 0);
        chk("t2_dsp_speed", 32'(dsp_speed), 32'd5);
        speed = 3'd1; interp = 1'b0;   // ignored until the next latch point
        nstop = 0;
        for (int i = 1; i <= 'h3FF + 2; i++) begin
            dsp_addr = 20'(i);
            step("t2_sweep", 0, 0, 0, 0);
            nstop += int'(dsp_stop);
        end
        chk("t2_dsp_stop_count", 32'(nstop), 32'd1);
        chk("t2_speed_held", 32'(dsp_speed), 32'd5);

        // Pause and stop together while recording: stop only
        rec_addr = 20'h200;
        step("t4_rec", 1, 0, 0, 0);
        step("t4_pause_stop", 0, 0, 1, 1);
        chk("t4_no_rec_pause", 32'(rec_pause), 32'd0);
        chk("t4_end_addr", 32'(end_addr), 32'h200);
        // Playback pause / resume with re-latched speed
        dsp_addr = '0; speed = 3'd2;
        step("t4_play", 0, 1, 0, 0);
        step("t4_pause", 0, 0, 1, 0);
        speed = 3'd7;
        step("t4_resume", 0, 0, 1, 0);
        chk("t4_relatch", 32'(dsp_speed), 32'd7);
        step("t4_stop", 0, 0, 0, 1);

        // Auto-stop at the last writable word
        rec_addr = 20'h10;
        step("t5_rec", 1, 0, 0, 0);
        rec_addr = c_max;
        #1;
        chk("t5_we_at_max", 32'(sram_we_n), 32'd0);
        chk("t5_addr_at_max", 32'(sram_addr), 32'(c_max));
        step("t5_autostop", 0, 0, 0, 0);
        chk("t5_end_max", 32'(end_addr), 32'(c_max));
        chk("t5_we_off", 32'(sram_we_n), 32'd1);

        // Random key traffic against the model
        for (int i = 0; i < 400; i++) begin
            rec_addr = ($urandom_range(0, 31) == 0) ? c_max : 20'($urandom_range(0, 'h7FF));
            dsp_addr = 20'($urandom_range(0, 'h500));
            speed    = 3'($urandom);
            interp   = 1'($urandom);
            step("rand", $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        // Reset in the middle of playback
        rec_addr = 20'h100;
        step("t6_stop", 0, 0, 0, 1);
        step("t6_rec", 1, 0, 0, 0);
        step("t6_rec_stop", 0, 0, 0, 1);
        dsp_addr = '0;
        step("t6_play", 0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("t6_after", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_aud_mode_ctrl
`default_nettype wire
